// File: rtl/valve_route_sequencer_pkg.sv
// Shared types and constants for the valve route sequencer: FSM states,
// the peristaltic pump phase table and the all-closed valve patterns.
package valve_route_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    PUMP,
    RELEASE
  } vrs_state_e;

  localparam int unsigned N_PHASES = 6;

  // Entry 0 is the first forward phase (p[2:0] = 001).
  localparam logic [N_PHASES-1:0][2:0] PUMP_PHASES = {
    3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001
  };

  localparam logic [2:0] P_CLOSED = 3'b111;

  localparam int unsigned N_CTRL_DFLT = 13;
  localparam logic [N_CTRL_DFLT-1:0] C_CLOSED = '1;

  function automatic logic [2:0] phase_pattern(input logic [2:0] idx);
    return (idx < 3'(N_PHASES)) ? PUMP_PHASES[idx] : P_CLOSED;
  endfunction

endpackage

// File: rtl/valve_route_sequencer_pump_phase_gen.sv
// Pump phase generator: steps the 3-valve pump through its phase table,
// holding each phase dwell+1 clocks for a given number of full cycles.
module valve_route_sequencer_pump_phase_gen
  import valve_route_sequencer_pkg::*;
#(
  parameter int unsigned CYC_W   = 8,
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [CYC_W-1:0]   cycles,
  input  logic               stop,
  output logic [2:0]         p,
  output logic               last
);

  logic               active;
  logic [2:0]         idx;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [CYC_W-1:0]   cyc_cnt;
  logic [2:0]         p_q;

  logic [2:0] first_idx;
  logic [2:0] last_idx;
  logic [2:0] step_idx;
  logic       phase_end;
  logic       at_last_idx;

  always_comb begin
    first_idx   = dir ? 3'd5 : 3'd0;
    last_idx    = dir ? 3'd0 : 3'd5;
    phase_end   = (dwell_cnt == dwell);
    at_last_idx = (idx == last_idx);
    step_idx    = at_last_idx ? first_idx : (dir ? idx - 3'd1 : idx + 3'd1);
    last        = active && phase_end && at_last_idx && (cyc_cnt == CYC_W'(1));
  end

  // p is registered alongside idx so the pattern changes on the same edge
  // as the phase index rather than one decode later.
  always_ff @(posedge clk) begin
    if (rst) begin
      active    <= 1'b0;
      idx       <= '0;
      dwell_cnt <= '0;
      cyc_cnt   <= '0;
      p_q       <= P_CLOSED;
    end else if (stop) begin
      active <= 1'b0;
      p_q    <= P_CLOSED;
    end else if (start) begin
      active    <= 1'b1;
      idx       <= first_idx;
      dwell_cnt <= '0;
      cyc_cnt   <= cycles;
      p_q       <= phase_pattern(first_idx);
    end else if (active) begin
      if (phase_end) begin
        dwell_cnt <= '0;
        if (last) begin
          active <= 1'b0;
          p_q    <= P_CLOSED;
        end else begin
          idx <= step_idx;
          p_q <= phase_pattern(step_idx);
          if (at_last_idx) begin
            cyc_cnt <= cyc_cnt - CYC_W'(1);
          end
        end
      end else begin
        dwell_cnt <= dwell_cnt + DWELL_W'(1);
      end
    end
  end

  assign p = p_q;

endmodule

// File: rtl/valve_route_sequencer.sv
// Valve route sequencer: accepts one route/pump command at a time and runs
// open route -> settle -> pump -> close all -> settle -> done.
module valve_route_sequencer
  import valve_route_sequencer_pkg::*;
#(
  parameter int unsigned N_CTRL     = 13,
  parameter int unsigned CYC_W      = 8,
  parameter int unsigned DWELL_W    = 16,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [N_CTRL-1:0]  cmd_route,
  input  logic [CYC_W-1:0]   cmd_cycles,
  input  logic               cmd_dir,
  input  logic [DWELL_W-1:0] cmd_dwell,
  input  logic               abort,
  output logic [N_CTRL-1:0]  c,
  output logic [2:0]         p,
  output logic               busy,
  output logic               done,
  output logic               done_aborted,
  output logic               cmd_err
);

  localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  vrs_state_e state, next_state;

  logic [SW-1:0]      settle_cnt, settle_cnt_next;
  logic [N_CTRL-1:0]  route_l;
  logic [CYC_W-1:0]   cycles_l;
  logic               dir_l;
  logic [DWELL_W-1:0] dwell_l;
  logic               aborted_l;

  logic [N_CTRL-1:0]  c_q, c_next;
  logic               busy_q, done_q, done_aborted_q, cmd_err_q;

  logic handshake, accept, reject, seg_end, abort_hit, finishing;
  logic pump_start, pump_stop, pump_last;

  valve_route_sequencer_pump_phase_gen #(
    .CYC_W   (CYC_W),
    .DWELL_W (DWELL_W)
  ) u_pump (
    .clk    (clk),
    .rst    (rst),
    .start  (pump_start),
    .dir    (dir_l),
    .dwell  (dwell_l),
    .cycles (cycles_l),
    .stop   (pump_stop),
    .p      (p),
    .last   (pump_last)
  );

  always_comb begin
    handshake  = cmd_valid && (state == IDLE);
    accept     = handshake && (|cmd_route);
    reject     = handshake && !(|cmd_route);
    seg_end    = (settle_cnt == SETTLE_LAST);
    abort_hit  = abort && ((state == SETTLE) || (state == PUMP));
    finishing  = (state == RELEASE) && seg_end;
    next_state = state;
    pump_start = 1'b0;
    pump_stop  = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) next_state = SETTLE;
      end
      SETTLE: begin
        if (abort) begin
          next_state = RELEASE;
        end else if (seg_end) begin
          if (cycles_l != '0) begin
            next_state = PUMP;
            pump_start = 1'b1;
          end else begin
            next_state = RELEASE;
          end
        end
      end
      PUMP: begin
        if (abort) begin
          next_state = RELEASE;
          pump_stop  = 1'b1;
        end else if (pump_last) begin
          next_state = RELEASE;
        end
      end
      RELEASE: begin
        if (seg_end) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase

    settle_cnt_next = (next_state != state) ? '0 : settle_cnt + SW'(1);

    // Route fields are not latched yet in the handshake cycle, so the
    // opening pattern comes straight from the command bus.
    if (accept) begin
      c_next = ~cmd_route;
    end else if ((next_state == SETTLE) || (next_state == PUMP)) begin
      c_next = ~route_l;
    end else begin
      c_next = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      settle_cnt     <= '0;
      route_l        <= '0;
      cycles_l       <= '0;
      dir_l          <= 1'b0;
      dwell_l        <= '0;
      aborted_l      <= 1'b0;
      c_q            <= '1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      done_aborted_q <= 1'b0;
      cmd_err_q      <= 1'b0;
    end else begin
      state      <= next_state;
      settle_cnt <= settle_cnt_next;
      if (accept) begin
        route_l   <= cmd_route;
        cycles_l  <= cmd_cycles;
        dir_l     <= cmd_dir;
        dwell_l   <= cmd_dwell;
        aborted_l <= 1'b0;
      end else if (abort_hit) begin
        aborted_l <= 1'b1;
      end
      c_q            <= c_next;
      busy_q         <= (next_state != IDLE);
      done_q         <= finishing;
      done_aborted_q <= finishing && aborted_l;
      cmd_err_q      <= reject;
    end
  end

  assign cmd_ready    = (state == IDLE);
  assign c            = c_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign done_aborted = done_aborted_q;
  assign cmd_err      = cmd_err_q;

endmodule
